ipml_fifo_rd_unpacker: RTL and testbench
========================================

// Module: ipml_fifo_rd_unpacker
// PURPOSE
//  Consumer end of the show-ahead (prefetch) FIFO read interface: pops wide words (rd_vld/rd_en
//  handshake, pop = vld & en) and serialises each into c_RATIO narrow beats on a valid/ready stream.
//  Sits in the rd_clk domain between an afifo_16i_64o-style FIFO and the narrow pixel/packet datapath.
//  Sustains one narrow beat per cycle with no bubble at word boundaries.
// PARAMETERS
//  c_IN_WIDTH    64  wide word width from FIFO; must equal c_OUT_WIDTH*c_RATIO
//  c_OUT_WIDTH   16  narrow output beat width
//  c_RATIO       4   beats per word; power of two, 2..32
//  c_LSB_FIRST   1   1: beat 0 = bits [c_OUT_WIDTH-1:0]; 0: beat 0 = most-significant slice
// PORTS
//  rd_clk        in   1            clock (FIFO read clock)
//  rd_rst        in   1            reset, synchronous, active-high
//  fifo_rd_data  in   c_IN_WIDTH   FIFO head word, valid while fifo_rd_vld=1
//  fifo_rd_vld   in   1            FIFO head word valid
//  fifo_rd_en    out  1            pop request; word consumed at edge where fifo_rd_vld&fifo_rd_en
//  out_data      out  c_OUT_WIDTH  narrow beat
//  out_vld       out  1            beat valid
//  out_rdy       in   1            downstream ready; beat transferred when out_vld&out_rdy
//  out_last      out  1            current beat is last slice of its word
//  flush         in   1            (UNPACK_FLUSH_EN only) discard remaining slices of held word
// BEHAVIOUR
//  - Interface: one clock (rd_clk); reset rd_rst is synchronous and active-high.
//  - State: hold_reg[c_IN_WIDTH], hold_vld, lane_cnt[log2(c_RATIO)]. Two states: EMPTY (hold_vld=0),
//    HOLD (hold_vld=1). Reset -> EMPTY, lane_cnt=0, hold_reg=0.
//  - Reset values: fifo_rd_en=0, out_data=0, out_vld=0, out_last=0.
//  - out_vld=hold_vld; out_data=slice lane_cnt (or c_RATIO-1-lane_cnt if c_LSB_FIRST=0) of hold_reg;
//    out_last=hold_vld & (lane_cnt==c_RATIO-1). All outputs driven from registers + mux only.
//  - xfer=out_vld&out_rdy; drain=xfer&out_last.
//  - fifo_rd_en = fifo_rd_vld & (~hold_vld | drain); never asserted with fifo_rd_vld=0.
//  - Load (fifo_rd_vld&fifo_rd_en): hold_reg<=fifo_rd_data, hold_vld<=1, lane_cnt<=0.
//  - xfer without drain: lane_cnt<=lane_cnt+1. drain without load: hold_vld<=0, lane_cnt<=0.
//  - drain and load same edge: reload, no bubble -> back-to-back words give continuous out_vld.
//  - Latency: word popped at edge N -> beat 0 on out_data in cycle N+1; last beat earliest N+c_RATIO.
//  - Backpressure: out_rdy=0 holds out_data/out_vld/out_last/lane_cnt stable; no pop occurs.
//  - FIFO empty (fifo_rd_vld=0) at drain: go EMPTY, out_vld=0 next cycle; no spurious pop.
//  - lane_cnt wraps only via drain/reload; never exceeds c_RATIO-1.
//  - rd_rst mid-word: remaining slices discarded, EMPTY next cycle; word at FIFO head not popped
//    during reset cycle (fifo_rd_en forced 0 while rd_rst=1).
// CONFIGURATION
//  - Macro UNPACK_FLUSH_EN defined: flush port present. flush=1 forces drain behaviour regardless
//    of out_rdy: held word discarded (hold_vld<=0, lane_cnt<=0) and, if fifo_rd_vld=1, next word
//    loaded same edge; fifo_rd_en = fifo_rd_vld & (~hold_vld | drain | flush). flush has priority
//    over xfer; rd_rst has priority over flush.
//  - Macro undefined: no flush port; logic as above without flush term.
// TESTING
//  1 Word 0x4444_3333_2222_1111, out_rdy=1 -> beats 0x1111,0x2222,0x3333,0x4444 cycles N+1..N+4,
//    out_last only on 0x4444.
//  2 c_LSB_FIRST=0, same word -> 0x4444,0x3333,0x2222,0x1111.
//  3 Two words queued, out_rdy=1 -> 8 consecutive out_vld cycles; fifo_rd_en pulses on first
//    cycle and on cycle of beat 4 only.
//  4 out_rdy=0 for 5 cycles during beat 2 -> out_data=0x3333 stable, fifo_rd_en=0, then resumes.
//  5 rd_rst=1 at beat 1 with second word pending -> out_vld=0 next cycle, fifo_rd_en=0 during reset,
//    after release second word emits 4 beats.
//  6 UNPACK_FLUSH_EN: flush=1 at beat 1, next word 0x8888_7777_6666_5555 ready -> next out_data=0x5555.

Source files
------------

// File: rtl/ipml_fifo_rd_unpacker.sv
// ipml_fifo_rd_unpacker
//   Read-side unpacker for a show-ahead FIFO. Pops one wide word at a time and
//   serialises it into c_RATIO narrow beats on a valid/ready stream. A word can
//   be reloaded on the same edge that its last beat leaves, so back-to-back
//   words stream with no bubble.
//   Optional feature: define UNPACK_FLUSH_EN to add the `flush` input, which
//   discards the rest of the held word regardless of out_rdy.
module ipml_fifo_rd_unpacker #(
   parameter int c_IN_WIDTH  = 64,
   parameter int c_OUT_WIDTH = 16,
   parameter int c_RATIO     = 4,
   parameter int c_LSB_FIRST = 1
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst,
   input  logic [c_IN_WIDTH-1:0]  fifo_rd_data,
   input  logic                   fifo_rd_vld,
   output logic                   fifo_rd_en,
   output logic [c_OUT_WIDTH-1:0] out_data,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic                   out_last
`ifdef UNPACK_FLUSH_EN
   ,
   input  logic                   flush
`endif
);

   localparam int                  c_LANE_W    = $clog2(c_RATIO);
   localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_RATIO - 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [c_IN_WIDTH-1:0]   hold_q, hold_d;
   logic [c_LANE_W-1:0]     lane_q, lane_d;
   logic [c_LANE_W-1:0]     sel_s;
   logic [c_OUT_WIDTH-1:0]  slice_s [c_RATIO];
   logic                    hold_vld_s;
   logic                    last_s;
   logic                    xfer_s;
   logic                    drain_s;
   logic                    flush_s;
   logic                    load_s;

   // Split the held word into its narrow slices, slice 0 = least-significant bits.
   for (genvar gi = 0; gi < c_RATIO; gi++) begin : g_slice
      assign slice_s[gi] = hold_q[gi*c_OUT_WIDTH +: c_OUT_WIDTH];
   end

   // Beat order: either walk slices upward from the LSB or downward from the MSB.
   if (c_LSB_FIRST != 0) begin : g_lsb_first
      assign sel_s = lane_q;
   end else begin : g_msb_first
      assign sel_s = c_LAST_LANE - lane_q;
   end

`ifdef UNPACK_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   assign hold_vld_s = (state_q == ST_HOLD);
   assign last_s     = hold_vld_s & (lane_q == c_LAST_LANE);
   assign xfer_s     = hold_vld_s & out_rdy;
   assign drain_s    = xfer_s & last_s;

   // Pop only when the FIFO has a word and the holding slot is free (or being
   // freed this edge); never during reset so the head word survives it.
   assign fifo_rd_en = ~rd_rst & fifo_rd_vld & (~hold_vld_s | drain_s | flush_s);
   assign load_s     = fifo_rd_en;

   // Outputs come straight from state registers through the slice mux.
   assign out_vld  = hold_vld_s;
   assign out_last = last_s;
   assign out_data = slice_s[sel_s];

   // Next-state: load wins, then drain/flush empties, then a plain beat advances the lane.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      lane_d  = lane_q;
      if (load_s) begin
         state_d = ST_HOLD;
         hold_d  = fifo_rd_data;
         lane_d  = {c_LANE_W{1'b0}};
      end else if (drain_s | flush_s) begin
         state_d = ST_EMPTY;
         lane_d  = {c_LANE_W{1'b0}};
      end else if (xfer_s) begin
         lane_d  = lane_q + c_LANE_W'(1);
      end else begin
         state_d = state_q;
      end
   end

   // State registers with synchronous reset that discards any held word.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q <= ST_EMPTY;
         hold_q  <= {c_IN_WIDTH{1'b0}};
         lane_q  <= {c_LANE_W{1'b0}};
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         lane_q  <= lane_d;
      end
   end

endmodule

// File: tb/tb_ipml_fifo_rd_unpacker.sv
// Bench for ipml_fifo_rd_unpacker: two instances (LSB-first and MSB-first) share
// one FIFO model. Every word the FIFO hands over becomes c_RATIO expected beats in
// a scoreboard queue; a negedge monitor compares and retires beats on each transfer.
module tb_ipml_fifo_rd_unpacker;

   localparam int W_IN  = 64;
   localparam int W_OUT = 16;
   localparam int R     = 4;

   typedef struct packed {
      logic [W_IN-1:0] w;
      int unsigned     idx;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [W_IN-1:0]  fifo_rd_data;
   logic             fifo_rd_vld;
   logic             out_rdy;
   logic             flush;
   logic             fifo_rd_en_l, fifo_rd_en_m;
   logic [W_OUT-1:0] out_data_l, out_data_m;
   logic             out_vld_l, out_vld_m;
   logic             out_last_l, out_last_m;

   logic [W_IN-1:0]  fifo_q [$];
   beat_t            exp_q  [$];
   logic             gate;
   logic             mon_en = 1'b0;
   logic             final_req = 1'b0;
   int               to_cnt = 0;
   int               checks = 0;
   int               failures = 0;

   always #5 clk = ~clk;

   ipml_fifo_rd_unpacker #(.c_IN_WIDTH(W_IN), .c_OUT_WIDTH(W_OUT), .c_RATIO(R), .c_LSB_FIRST(1)) dut_l (
      .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
      .fifo_rd_en(fifo_rd_en_l), .out_data(out_data_l), .out_vld(out_vld_l), .out_rdy(out_rdy),
      .out_last(out_last_l)
`ifdef UNPACK_FLUSH_EN
      , .flush(flush)
`endif
   );

   ipml_fifo_rd_unpacker #(.c_IN_WIDTH(W_IN), .c_OUT_WIDTH(W_OUT), .c_RATIO(R), .c_LSB_FIRST(0)) dut_m (
      .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
      .fifo_rd_en(fifo_rd_en_m), .out_data(out_data_m), .out_vld(out_vld_m), .out_rdy(out_rdy),
      .out_last(out_last_m)
`ifdef UNPACK_FLUSH_EN
      , .flush(flush)
`endif
   );

   // k-th narrow slice of a word counted from the least-significant end.
   function automatic logic [W_OUT-1:0] slice(input logic [W_IN-1:0] w, input int k);
      logic [W_IN-1:0] t;
      t = w >> (k * W_OUT);
      return t[W_OUT-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: compare at negedge, then advance the reference to the next edge.
   initial begin
      int   n;
      logic rst_prev;
      logic exp_en;
      logic final_done;
      rst_prev   = 1'b0;
      final_done = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            n = exp_q.size();
            if (rst_prev) begin
               chk("rst_data_l", 64'(out_data_l), 64'(0));
               chk("rst_data_m", 64'(out_data_m), 64'(0));
            end
            chk("vld_l", 64'(out_vld_l), 64'(n > 0));
            chk("vld_m", 64'(out_vld_m), 64'(n > 0));
            if (n > 0) begin
               chk("data_l", 64'(out_data_l), 64'(slice(exp_q[0].w, int'(exp_q[0].idx))));
               chk("data_m", 64'(out_data_m), 64'(slice(exp_q[0].w, R - 1 - int'(exp_q[0].idx))));
               chk("last_l", 64'(out_last_l), 64'(exp_q[0].idx == R - 1));
               chk("last_m", 64'(out_last_m), 64'(exp_q[0].idx == R - 1));
            end else begin
               chk("last_idle_l", 64'(out_last_l), 64'(0));
               chk("last_idle_m", 64'(out_last_m), 64'(0));
            end
            exp_en = !rst && fifo_rd_vld && (n == 0 || (n == 1 && out_rdy) || flush);
            chk("rd_en_l", 64'(fifo_rd_en_l), 64'(exp_en));
            chk("rd_en_m", 64'(fifo_rd_en_m), 64'(exp_en));
            if (rst) begin
               exp_q.delete();
            end else begin
               if (flush) exp_q.delete();
               else if (n > 0 && out_rdy) void'(exp_q.pop_front());
               if (fifo_rd_vld && fifo_rd_en_l) begin
                  for (int k = 0; k < R; k++) exp_q.push_back('{w: fifo_rd_data, idx: k});
               end
            end
            rst_prev = rst;
            if (final_req && !final_done) begin
               chk("drain_timeouts", 64'(to_cnt), 64'(0));
               chk("drained_fifo", 64'(fifo_q.size()), 64'(0));
               chk("drained_beats", 64'(exp_q.size()), 64'(0));
               final_done = 1'b1;
            end
         end
      end
   end

   task automatic drive_fifo();
      fifo_rd_vld  = gate && (fifo_q.size() > 0);
      fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : {$urandom, $urandom};
   endtask

   // One clock: note whether the FIFO pops at the coming edge, then update it after the edge.
   task automatic cycle();
      logic pop;
      @(negedge clk);
      pop = fifo_rd_vld && fifo_rd_en_l;
      @(posedge clk);
      #1;
      if (pop) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   task automatic push_word(input logic [W_IN-1:0] w);
      fifo_q.push_back(w);
      drive_fifo();
   endtask

   task automatic wait_beat(input int unsigned k);
      int i;
      for (i = 0; i < 40; i++) begin
         if (exp_q.size() > 0 && exp_q[0].idx == k) break;
         cycle();
      end
      if (i == 40) to_cnt++;
   endtask

   task automatic run(input int c);
      for (int i = 0; i < c; i++) cycle();
   endtask

   // Stimulus: directed scenarios, a randomized stretch, then a full drain.
   initial begin
      rst     = 1'b1;
      out_rdy = 1'b1;
      flush   = 1'b0;
      gate    = 1'b1;
      drive_fifo();
      cycle();
      mon_en = 1'b1;
      push_word(64'h4444_3333_2222_1111);
      run(2);
      rst = 1'b0;
      run(8);
      // back-to-back words: continuous beats
      push_word(64'hAAAA_BBBB_CCCC_DDDD);
      push_word(64'h0123_4567_89AB_CDEF);
      run(12);
      // backpressure at beat 2
      push_word(64'h4444_3333_2222_1111);
      wait_beat(2);
      out_rdy = 1'b0;
      run(5);
      out_rdy = 1'b1;
      run(6);
      // reset at beat 1 with a second word pending
      push_word(64'h1357_9BDF_2468_ACE0);
      push_word(64'hFEDC_BA98_7654_3210);
      wait_beat(1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      run(8);
`ifdef UNPACK_FLUSH_EN
      push_word(64'h4444_3333_2222_1111);
      push_word(64'h8888_7777_6666_5555);
      wait_beat(1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      run(8);
`endif
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         out_rdy = ($urandom % 4) != 0;
         gate    = ($urandom % 8) != 0;
         rst     = ($urandom % 100) == 0;
`ifdef UNPACK_FLUSH_EN
         flush   = ($urandom % 32) == 0;
`endif
         if (fifo_q.size() < 3 && ($urandom % 2) == 1) fifo_q.push_back({$urandom, $urandom});
         drive_fifo();
         cycle();
      end
      // drain everything with a bounded wait
      out_rdy = 1'b1;
      gate    = 1'b1;
      rst     = 1'b0;
      flush   = 1'b0;
      drive_fifo();
      begin
         int i;
         for (i = 0; i < 300; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0) break;
            cycle();
         end
         if (i == 300) to_cnt++;
      end
      final_req = 1'b1;
      run(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
